// File: rtl/gen1_boot_core_nios2_debug_scan_master.sv
// Virtual-JTAG initiator for the Nios II debug slave: one UIR/CDR/SDR/UDR/RTI scan per command.
// Response (3+DR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk after accept; new commands stall until the response is taken.
module gen1_boot_core_nios2_debug_scan_master #(
   parameter int TCK_DIV    = 2,
   parameter int DR_WIDTH   = 38,
   parameter int RTI_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [1:0]          rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [1:0]          vji_ir_in,
   input  logic [1:0]          vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int PH_W    = (2*TCK_DIV > 1) ? $clog2(2*TCK_DIV) : 1;
   localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [PH_W-1:0]  PH_SMP   = PH_W'(TCK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(TCK_DIV);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2*TCK_DIV - 1);
   localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(DR_WIDTH - 1);
   localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UIR,
      S_CDR,
      S_SDR,
      S_UDR,
      S_RTI,
      S_RESP
   } state_t;

   state_t              state_q;
   state_t              state_nxt;
   logic                armed_q;
   logic [PH_W-1:0]     ph_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [1:0]          ir_q;
   logic [1:0]          ir_out_q;
   logic [DR_WIDTH-1:0] tx_q;
   logic [DR_WIDTH-1:0] rx_q;
   logic [DR_WIDTH-1:0] rx_shift;
   logic                active;
   logic                accept;
   logic                period_end;
   logic                sample_pt;

   // armed_q keeps cmd_ready low until the first clk edge after reset release
   assign cmd_ready  = armed_q && (state_q == S_IDLE);
   assign accept     = cmd_valid && cmd_ready;
   assign active     = (state_q != S_IDLE) && (state_q != S_RESP);
   assign period_end = active && (ph_q == PH_LAST);
   assign sample_pt  = active && (ph_q == PH_SMP);

   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_dr     = rx_q;
   assign rsp_ir_out = ir_out_q;
   assign vji_tck    = active && (ph_q >= PH_HIGH);
   assign vji_ir_in  = (state_q == S_IDLE) ? 2'b00 : ir_q;

   // first TDO sample enters at the MSB and walks down to bit 0 after DR_WIDTH samples
   always_comb begin
      rx_shift = rx_q >> 1;
      rx_shift[DR_WIDTH-1] = vji_tdo;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      vji_uir   = 1'b0;
      vji_cdr   = 1'b0;
      vji_sdr   = 1'b0;
      vji_udr   = 1'b0;
      vji_rti   = 1'b0;
      vji_tdi   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) state_nxt = S_UIR;
         end
         S_UIR: begin
            vji_uir = 1'b1;
            if (period_end) state_nxt = S_CDR;
         end
         S_CDR: begin
            vji_cdr = 1'b1;
            if (period_end) state_nxt = S_SDR;
         end
         S_SDR: begin
            vji_sdr = 1'b1;
            vji_tdi = tx_q[0];
            if (period_end && (cnt_q == SDR_LAST)) state_nxt = S_UDR;
         end
         S_UDR: begin
            vji_udr = 1'b1;
            if (period_end) state_nxt = S_RTI;
         end
         S_RTI: begin
            vji_rti = 1'b1;
            if (period_end && (cnt_q == RTI_LAST)) state_nxt = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed_q  <= 1'b0;
         ph_q     <= '0;
         cnt_q    <= '0;
         ir_q     <= 2'b00;
         ir_out_q <= 2'b00;
         tx_q     <= '0;
         rx_q     <= '0;
      end else begin
         armed_q <= 1'b1;
         if (accept) begin
            ir_q  <= cmd_ir;
            tx_q  <= cmd_dr;
            ph_q  <= '0;
            cnt_q <= '0;
         end else if (active) begin
            ph_q <= period_end ? '0 : ph_q + 1'b1;
            if (sample_pt && (state_q == S_UIR)) ir_out_q <= vji_ir_out;
            if (sample_pt && (state_q == S_SDR)) rx_q <= rx_shift;
            // tdi advances only at the period boundary so it is stable across the tck rise
            if (period_end) begin
               if (state_q == S_SDR) tx_q <= tx_q >> 1;
               cnt_q <= (state_nxt != state_q) ? '0 : cnt_q + 1'b1;
            end
         end
      end
   end

`ifndef SYNTHESIS
   a_flags_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}));
   a_tck_quiet: assert property (@(posedge clk) disable iff (reset)
      (!active |-> !vji_tck));
`endif

endmodule

// File: tb/tb_gen1_boot_core_nios2_debug_scan_master.sv
// Bench for the debug scan master: loopback slave model, table + random scans, reset/backpressure/fast-tck cases.
module tb_gen1_boot_core_nios2_debug_scan_master;

   localparam int DIV   = 2;
   localparam int DRW   = 38;
   localparam int RTI   = 2;
   localparam int LAT_A = (3 + DRW + RTI) * 2 * DIV;
   localparam int LAT_B = (3 + 4 + RTI) * 2 * 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic            a_cmd_valid = 1'b0, a_rsp_ready = 1'b0;
   logic            a_cmd_ready, a_rsp_valid;
   logic [1:0]      a_cmd_ir = 2'b00, a_ir_out = 2'b00;
   logic [1:0]      a_rsp_ir_out, a_ir_in;
   logic [DRW-1:0]  a_cmd_dr = '0;
   logic [DRW-1:0]  a_rsp_dr;
   logic            a_tck, a_tdi, a_tdo, a_uir, a_cdr, a_sdr, a_udr, a_rti;

   logic            b_cmd_valid = 1'b0, b_rsp_ready = 1'b0;
   logic            b_cmd_ready, b_rsp_valid;
   logic [1:0]      b_cmd_ir = 2'b00;
   logic [1:0]      b_rsp_ir_out, b_ir_in, b_ir_out;
   logic [3:0]      b_cmd_dr = 4'h0;
   logic [3:0]      b_rsp_dr;
   logic            b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;

   assign b_tdo    = 1'b1;
   assign b_ir_out = 2'b00;

   gen1_boot_core_nios2_debug_scan_master #(.TCK_DIV(DIV), .DR_WIDTH(DRW), .RTI_CYCLES(RTI)) dut_a (
      .clk(clk), .reset(reset),
      .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_ir(a_cmd_ir), .cmd_dr(a_cmd_dr),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_dr(a_rsp_dr), .rsp_ir_out(a_rsp_ir_out),
      .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo), .vji_ir_in(a_ir_in), .vji_ir_out(a_ir_out),
      .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr), .vji_rti(a_rti)
   );

   gen1_boot_core_nios2_debug_scan_master #(.TCK_DIV(1), .DR_WIDTH(4), .RTI_CYCLES(RTI)) dut_b (
      .clk(clk), .reset(reset),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ir(b_cmd_ir), .cmd_dr(b_cmd_dr),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_dr(b_rsp_dr), .rsp_ir_out(b_rsp_ir_out),
      .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo), .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out),
      .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti)
   );

   // debug-slave model: sr shifts toward bit 0 on tck rise during SDR, tdo is sr[0]
   logic [DRW-1:0] sr;
   logic [DRW-1:0] sr_pre = '0;
   logic           sr_load = 1'b0;
   assign a_tdo = sr[0];

   always @(posedge a_tck or posedge sr_load) begin
      if (sr_load) sr <= sr_pre;
      else if (a_sdr) sr <= {a_tdi, sr[DRW-1:1]};
   end

   logic       mon_clr = 1'b0;
   logic [1:0] cur_ir = 2'b00;
   int         n_uir, n_cdr, n_sdr, n_udr, n_rti, ir_bad;
   bit         a_tdi_q[$];
   bit         b_tdi_q[$];
   int         excl_bad = 0;

   always @(posedge a_tck or posedge mon_clr) begin
      if (mon_clr) begin
         n_uir <= 0; n_cdr <= 0; n_sdr <= 0; n_udr <= 0; n_rti <= 0; ir_bad <= 0;
         a_tdi_q.delete();
      end else begin
         if (a_uir) n_uir <= n_uir + 1;
         if (a_cdr) n_cdr <= n_cdr + 1;
         if (a_sdr) begin
            n_sdr <= n_sdr + 1;
            a_tdi_q.push_back(a_tdi);
         end
         if (a_udr) n_udr <= n_udr + 1;
         if (a_rti) n_rti <= n_rti + 1;
         if (a_ir_in !== cur_ir) ir_bad <= ir_bad + 1;
      end
   end

   always @(posedge b_tck or posedge mon_clr) begin
      if (mon_clr) b_tdi_q.delete();
      else if (b_sdr) b_tdi_q.push_back(b_tdi);
   end

   // flags exclusive, quiet when idle or responding, tdi only in SDR, ir_in cleared in idle
   always @(negedge clk) begin
      if (!reset) begin
         if (($countones({a_uir, a_cdr, a_sdr, a_udr, a_rti}) > 1) ||
             ($countones({b_uir, b_cdr, b_sdr, b_udr, b_rti}) > 1) ||
             ((a_cmd_ready || a_rsp_valid) && ({a_uir, a_cdr, a_sdr, a_udr, a_rti, a_tck} != 6'b0)) ||
             ((b_cmd_ready || b_rsp_valid) && ({b_uir, b_cdr, b_sdr, b_udr, b_rti, b_tck} != 6'b0)) ||
             (!a_sdr && a_tdi) || (!b_sdr && b_tdi) ||
             (a_cmd_ready && (a_ir_in != 2'b00)) || (b_cmd_ready && (b_ir_in != 2'b00)))
            excl_bad <= excl_bad + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic pulse_clr();
      mon_clr = 1'b1; #1; mon_clr = 1'b0;
   endtask

   task automatic preload(input logic [DRW-1:0] v);
      sr_pre = v; sr_load = 1'b1; #1; sr_load = 1'b0;
   endtask

   task automatic a_send(input logic [1:0] ir, input logic [DRW-1:0] dr);
      bit got;
      got = 1'b0;
      a_cmd_ir = ir; a_cmd_dr = dr; a_cmd_valid = 1'b1;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (a_cmd_ready) got = 1'b1;
      end
      check("accept_wait", 64'(got), 64'(1));
      @(posedge clk); #1;
      a_cmd_valid = 1'b0;
      a_cmd_ir = ~ir;
      a_cmd_dr = DRW'({$urandom(), $urandom()});
   endtask

   task automatic a_wait_rsp(output int lat);
      lat = 0;
      while (lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (a_rsp_valid) break;
      end
   endtask

   task automatic a_take();
      a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic [1:0]     ir;
      logic [DRW-1:0] dr;
      logic [DRW-1:0] pre;
      logic [1:0]     iro;
      logic [DRW-1:0] exp_rsp;
      logic [DRW-1:0] exp_sr;
      logic [1:0]     exp_iro;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int             lat;
      bit             got;
      int             bad;
      logic [DRW-1:0] word;
      logic [DRW-1:0] hold_dr;
      logic [1:0]     hold_ir;
      logic [DRW-1:0] dr2;
      logic [3:0]     bw;

      vecs[0] = '{2'b01, 38'h2A_5A5A_5A5A, 38'h15_1234_5678, 2'b00, 38'h15_1234_5678, 38'h2A_5A5A_5A5A, 2'b00};
      vecs[1] = '{2'b10, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b10, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 2'b10};
      vecs[2] = '{2'b11, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 2'b01, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b01};
      vecs[3] = '{2'b00, 38'h00_0000_0001, 38'h20_0000_0000, 2'b11, 38'h20_0000_0000, 38'h00_0000_0001, 2'b11};
      for (int i = 4; i < 12; i++) begin
         vecs[i].ir  = 2'($urandom_range(0, 3));
         vecs[i].dr  = DRW'({$urandom(), $urandom()});
         vecs[i].pre = DRW'({$urandom(), $urandom()});
         vecs[i].iro = 2'($urandom_range(0, 3));
         // loopback rule: response is the slave's prior contents, slave ends holding the command word
         vecs[i].exp_rsp = vecs[i].pre;
         vecs[i].exp_sr  = vecs[i].dr;
         vecs[i].exp_iro = vecs[i].iro;
      end

      #1;
      check("rst_cmd_ready", 64'(a_cmd_ready), 64'(0));
      check("rst_rsp_valid", 64'(a_rsp_valid), 64'(0));
      check("rst_vji", 64'({a_tck, a_tdi, a_ir_in, a_uir, a_cdr, a_sdr, a_udr, a_rti}), 64'(0));
      check("rst_rsp", 64'({a_rsp_dr, a_rsp_ir_out}), 64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("rel_cmd_ready", 64'({a_cmd_ready, b_cmd_ready}), 64'(2'b11));

      for (int v = 0; v < 12; v++) begin
         preload(vecs[v].pre);
         a_ir_out = vecs[v].iro;
         cur_ir = vecs[v].ir;
         pulse_clr();
         a_send(vecs[v].ir, vecs[v].dr);
         a_wait_rsp(lat);
         check("latency", 64'(lat), 64'(LAT_A));
         check("rsp_dr", 64'(a_rsp_dr), 64'(vecs[v].exp_rsp));
         check("rsp_ir_out", 64'(a_rsp_ir_out), 64'(vecs[v].exp_iro));
         check("slave_sr", 64'(sr), 64'(vecs[v].exp_sr));
         check("n_uir", 64'(n_uir), 64'(1));
         check("n_cdr", 64'(n_cdr), 64'(1));
         check("n_sdr", 64'(n_sdr), 64'(DRW));
         check("n_udr", 64'(n_udr), 64'(1));
         check("n_rti", 64'(n_rti), 64'(RTI));
         check("ir_in_held", 64'(ir_bad), 64'(0));
         word = '0;
         for (int i = 0; i < a_tdi_q.size() && i < DRW; i++) word[i] = a_tdi_q[i];
         check("tdi_seq", 64'(word), 64'(vecs[v].dr));
         a_take();
      end

      // response held under backpressure while a new command waits
      preload(38'h0A_CAFE_F00D);
      a_ir_out = 2'b01; cur_ir = 2'b11;
      pulse_clr();
      a_send(2'b11, 38'h11_2233_4455);
      a_wait_rsp(lat);
      check("bp_latency", 64'(lat), 64'(LAT_A));
      check("bp_rsp_dr", 64'(a_rsp_dr), 64'(38'h0A_CAFE_F00D));
      hold_dr = a_rsp_dr; hold_ir = a_rsp_ir_out;
      dr2 = 38'h33_0F0F_F0F0;
      a_cmd_valid = 1'b1; a_cmd_ir = 2'b10; a_cmd_dr = dr2;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (a_cmd_ready || !a_rsp_valid || (a_rsp_dr !== hold_dr) || (a_rsp_ir_out !== hold_ir) || a_uir)
            bad++;
      end
      check("bp_hold", 64'(bad), 64'(0));
      @(posedge clk); #1;
      a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
      check("bp_ready_after_take", 64'({a_cmd_ready, a_rsp_valid, a_uir}), 64'(3'b100));
      preload(38'h01_8000_0001);
      cur_ir = 2'b10;
      pulse_clr();
      @(posedge clk); #1;
      check("bp_accept_next_clk", 64'({a_cmd_ready, a_uir}), 64'(2'b01));
      a_cmd_valid = 1'b0; a_cmd_dr = '0;
      a_wait_rsp(lat);
      check("bp2_latency", 64'(lat), 64'(LAT_A));
      check("bp2_rsp_dr", 64'(a_rsp_dr), 64'(38'h01_8000_0001));
      check("bp2_slave_sr", 64'(sr), 64'(dr2));
      a_take();

      // fast tck, 4-bit DR, tdo tied high
      pulse_clr();
      b_cmd_ir = 2'b11; b_cmd_dr = 4'b1001; b_cmd_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (b_cmd_ready) got = 1'b1;
      end
      check("b_accept_wait", 64'(got), 64'(1));
      @(posedge clk); #1;
      b_cmd_valid = 1'b0; b_cmd_dr = 4'b0110;
      bad = 0;
      for (int k = 0; k < LAT_B; k++) begin
         @(negedge clk);
         if (b_tck !== k[0]) bad++;
      end
      check("b_tck_toggle", 64'(bad), 64'(0));
      check("b_rsp_not_early", 64'(b_rsp_valid), 64'(0));
      @(posedge clk); #1;
      check("b_rsp_on_time", 64'(b_rsp_valid), 64'(1));
      check("b_rsp_dr", 64'(b_rsp_dr), 64'(4'hF));
      bw = 4'h0;
      for (int i = 0; i < b_tdi_q.size() && i < 4; i++) bw[i] = b_tdi_q[i];
      check("b_tdi_count", 64'(b_tdi_q.size()), 64'(4));
      check("b_tdi_seq", 64'(bw), 64'(4'b1001));
      b_rsp_ready = 1'b1;
      @(posedge clk); #1;
      b_rsp_ready = 1'b0;

      // reset in the middle of SDR while tck is high
      preload(38'h2B_DEAD_BEEF);
      cur_ir = 2'b01;
      pulse_clr();
      a_send(2'b01, 38'h05_5555_AAAA);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (a_sdr) got = 1'b1;
      end
      repeat (12) @(negedge clk);
      for (int i = 0; i < 8 && !a_tck; i++) @(negedge clk);
      check("t1_mid_sdr_tck_high", 64'({got, a_sdr, a_tck}), 64'(3'b111));
      #1 reset = 1'b1;
      #1;
      check("t1_vji_zero", 64'({a_tck, a_tdi, a_ir_in, a_uir, a_cdr, a_sdr, a_udr, a_rti}), 64'(0));
      check("t1_ready_low", 64'({a_cmd_ready, a_rsp_valid}), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("t1_ready_after", 64'({a_cmd_ready, a_rsp_valid}), 64'(2'b10));
      check("t1_rsp_cleared", 64'(a_rsp_dr), 64'(0));
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_rsp_valid || a_tck) bad++;
      end
      check("t1_no_response", 64'(bad), 64'(0));

      check("flag_rules", 64'(excl_bad), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation timeout");
   end

endmodule
